// File: rtl/button_event_arbiter_pkg.sv
// Shared sizing helpers for the button event arbiter and its consumers.
// Consumers can size their event id bus from a channel count with id_width().
package button_event_arbiter_pkg;

  localparam int N_BTN_DEFAULT = 4;
  localparam int DEPTH_DEFAULT = 4;

  function automatic int id_width(input int n_btn);
    return (n_btn < 2) ? 1 : $clog2(n_btn);
  endfunction

  function automatic int fifo_ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int ID_W_DEFAULT       = id_width(N_BTN_DEFAULT);
  localparam int FIFO_PTR_W_DEFAULT = fifo_ptr_width(DEPTH_DEFAULT);

endpackage

// File: rtl/button_event_arbiter_event_fifo.sv
// Small synchronous event FIFO; pointers carry an extra wrap bit so full and
// empty can be told apart without a separate count.
module event_fifo
  import button_event_arbiter_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = fifo_ptr_width(DEPTH);

  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         wr_en, rd_en;

  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    rd_en    = pop && !empty;
    // a push into a full FIFO is only allowed when the head leaves in the same cycle
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q[PW-1:0]] = din;
        wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Latches per-channel press pulses, round-robin arbitrates them into an event
// FIFO and presents the ordered event stream on a valid/ready port.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int ID_W  = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_pulse,
  input  logic             flush,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N_BTN-1:0] pending,
  output logic [CNT_W-1:0] merge_cnt
);

  logic [N_BTN-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] merge_cnt_q, merge_cnt_d;

  logic             fifo_full, fifo_empty;
  logic             pop, push, grant_ok, grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic [N_BTN-1:0] grant_vec, merge_vec;
  logic [CNT_W+4:0] merge_sum;
  int               idx;
  int               merge_n;

  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign pending   = pending_q;
  assign merge_cnt = merge_cnt_q;

  always_comb begin
    grant_ok  = (|pending_q) && (!fifo_full || pop);
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (grant_ok) begin
      for (int k = 0; k < N_BTN; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_BTN) idx = idx - N_BTN;
        if (!grant_vld && pending_q[idx]) begin
          grant_vld = 1'b1;
          grant_idx = ID_W'(idx);
        end
      end
    end
    grant_vec = grant_vld ? (N_BTN'(1) << grant_idx) : '0;

    // a press on a channel that is still pending (and not leaving now) is folded in
    merge_vec = btn_pulse & pending_q & ~grant_vec;
    merge_n   = 0;
    for (int i = 0; i < N_BTN; i++) begin
      if (merge_vec[i]) merge_n = merge_n + 1;
    end
    merge_sum = {5'b0, merge_cnt_q} + (CNT_W+5)'(merge_n);

    pending_d   = pending_q;
    ptr_d       = ptr_q;
    merge_cnt_d = merge_cnt_q;
    push        = 1'b0;
    if (flush) begin
      pending_d = '0;
      ptr_d     = '0;
    end else begin
      pending_d   = (pending_q & ~grant_vec) | btn_pulse;
      push        = grant_vld;
      merge_cnt_d = (|merge_sum[CNT_W+4:CNT_W]) ? '1 : merge_sum[CNT_W-1:0];
      if (grant_vld) begin
        ptr_d = (grant_idx == ID_W'(N_BTN-1)) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= '0;
      ptr_q       <= '0;
      merge_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      merge_cnt_q <= merge_cnt_d;
    end
  end

  event_fifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .din     (grant_idx),
    .dout    (evt_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] btn_pulse;
  logic         flush;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_ready;
  logic [N-1:0] pending;
  logic [CW-1:0] merge_cnt;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN (N),
    .ID_W  (2),
    .DEPTH (D),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_pulse (btn_pulse),
    .flush     (flush),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .merge_cnt (merge_cnt)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [N-1:0] m_pend;
  int         m_ptr;
  int         m_q[$];
  int         m_merge;

  typedef struct {
    bit         rst;
    bit [N-1:0] btn;
    bit         rdy;
    bit         exp_valid;
    bit [1:0]   exp_id;
    bit [N-1:0] exp_pend;
  } vec_t;

  vec_t vecs[$];
  int   ids[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_ptr   = 0;
    m_q.delete();
    m_merge = 0;
  endtask

  task automatic model_step(input bit [N-1:0] b, input bit fl, input bit rdy);
    bit pop;
    int g;
    int mg;
    pop = (m_q.size() > 0) && rdy;
    if (fl) begin
      m_pend = '0;
      m_q.delete();
      m_ptr = 0;
      return;
    end
    g = -1;
    if (m_pend != 0 && (m_q.size() < D || pop)) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && m_pend[i]) g = i;
      end
    end
    mg = 0;
    for (int i = 0; i < N; i++) begin
      if (b[i] && m_pend[i] && i != g) mg++;
    end
    m_merge = (m_merge + mg > 255) ? 255 : m_merge + mg;
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_pend[g] = 1'b0;
      m_ptr = (g + 1) % N;
    end
    m_pend = m_pend | b;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check({tag, ".id"}, 32'(evt_id), 32'(m_q[0]));
    check({tag, ".pending"}, 32'(pending), 32'(m_pend));
    check({tag, ".merge"}, 32'(merge_cnt), 32'(m_merge));
  endtask

  task automatic cycle(input bit [N-1:0] b, input bit fl, input bit rdy);
    btn_pulse = b;
    flush     = fl;
    evt_ready = rdy;
    model_step(b, fl, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    btn_pulse = '0;
    flush     = 1'b0;
    evt_ready = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // drain with ready high, recording popped ids; bounded by a cycle budget
  task automatic drain(input string tag, input int budget);
    ids.delete();
    for (int c = 0; c < budget; c++) begin
      if (evt_valid) ids.push_back(int'(evt_id));
      cycle('0, 1'b0, 1'b1);
      check_model(tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit [N-1:0] b;
    bit         fl, rdy;

    // table: single press, then simultaneous presses from reset
    vecs.push_back('{1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b1111});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b1110});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b1100});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b1000});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b0011});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0010});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000});

    do_reset();
    check("reset.valid", 32'(evt_valid), 32'd0);
    check("reset.id", 32'(evt_id), 32'd0);
    check("reset.pending", 32'(pending), 32'd0);
    check("reset.merge", 32'(merge_cnt), 32'd0);

    foreach (vecs[v]) begin
      if (vecs[v].rst) do_reset();
      cycle(vecs[v].btn, 1'b0, vecs[v].rdy);
      check($sformatf("vec%0d.valid", v), 32'(evt_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) check($sformatf("vec%0d.id", v), 32'(evt_id), 32'(vecs[v].exp_id));
      check($sformatf("vec%0d.pending", v), 32'(pending), 32'(vecs[v].exp_pend));
      check($sformatf("vec%0d.merge", v), 32'(merge_cnt), 32'd0);
    end

    // fairness: channels 0 and 2 re-armed every cycle must alternate
    do_reset();
    ids.delete();
    for (int c = 0; c < 10; c++) begin
      if (evt_valid) ids.push_back(int'(evt_id));
      cycle(4'b0101, 1'b0, 1'b1);
      check_model("fair");
    end
    check("fair.count_ge6", 32'(ids.size() >= 6), 32'd1);
    foreach (ids[i]) check($sformatf("fair.id%0d", i), 32'(ids[i]), (i % 2 == 0) ? 32'd0 : 32'd2);

    // backpressure: fill FIFO, merge a repeat press, then drain in order
    do_reset();
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    check("bp.pending_held", 32'(pending), 32'b0010);
    check("bp.valid", 32'(evt_valid), 32'd1);
    cycle(4'b0010, 1'b0, 1'b0);
    check("bp.merge", 32'(merge_cnt), 32'd1);
    cycle(4'b0000, 1'b0, 1'b0);
    check("bp.stall_pending", 32'(pending), 32'b0010);
    check("bp.head", 32'(evt_id), 32'd0);
    drain("bp", 8);
    check("bp.count", 32'(ids.size()), 32'd5);
    if (ids.size() == 5) begin
      check("bp.ord0", 32'(ids[0]), 32'd0);
      check("bp.ord1", 32'(ids[1]), 32'd1);
      check("bp.ord2", 32'(ids[2]), 32'd2);
      check("bp.ord3", 32'(ids[3]), 32'd3);
      check("bp.ord4", 32'(ids[4]), 32'd1);
    end

    // same-cycle grant and new press on channel 3
    do_reset();
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    check("same.pending", 32'(pending), 32'b1000);
    check("same.merge", 32'(merge_cnt), 32'd0);
    drain("same", 6);
    check("same.count", 32'(ids.size()), 32'd2);
    foreach (ids[i]) check($sformatf("same.id%0d", i), 32'(ids[i]), 32'd3);

    // flush with three queued events and one pending press
    do_reset();
    cycle(4'b1011, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    check("flush.pre_pending", 32'(pending), 32'b0100);
    check("flush.pre_valid", 32'(evt_valid), 32'd1);
    cycle(4'b0001, 1'b1, 1'b1);
    check("flush.valid", 32'(evt_valid), 32'd0);
    check("flush.pending", 32'(pending), 32'd0);
    flush = 1'b0;

    // asynchronous reset between edges
    do_reset();
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    check_model("pre_arst");
    #3;
    reset_n = 1'b0;
    #1;
    check("arst.valid", 32'(evt_valid), 32'd0);
    check("arst.id", 32'(evt_id), 32'd0);
    check("arst.pending", 32'(pending), 32'd0);
    check("arst.merge", 32'(merge_cnt), 32'd0);
    do_reset();

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      b   = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      fl  = ($urandom_range(0, 47) == 0);
      if ((c % 120) < 50) rdy = ($urandom_range(0, 3) == 0);
      else                rdy = ($urandom_range(0, 3) != 0);
      cycle(b, fl, rdy);
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
